// File: rtl/vc_trace_line_sched.sv
// Trace-line scheduler: merges per-producer fragments into one character stream,
// inserting separators, a terminating newline and a length clamp.
module vc_trace_line_sched #(
  parameter int          NREQ   = 4,
  parameter int          NCHARS = 512,
  parameter logic [7:0]  SEP    = 8'h7C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [NREQ-1:0]   line_mask,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*8-1:0] req_char,
  input  logic [NREQ-1:0]   req_last,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [7:0]        out_char,
  output logic              line_done,
  output logic [15:0]       line_chars,
  output logic              overflow,
  output logic [31:0]       cycles
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_SEP  = 2'd2,
    ST_NL   = 2'd3
  } state_t;

  // Lowest set bit of m at or above start; MSB of the result flags "found".
  function automatic logic [IW:0] next_set(input logic [NREQ-1:0] m, input int start);
    logic [IW:0] r;
    r = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      r = ((i >= start) && m[i]) ? {1'b1, IW'(i)} : r;
    end
    return r;
  endfunction

  state_t          state_r;
  logic [IW-1:0]   idx_r;
  logic [NREQ-1:0] mask_r;
  logic [15:0]     line_chars_r;
  logic            overflow_r;
  logic            line_done_r;
  logic [31:0]     cycles_r;

  logic [NREQ-1:0] req_rdy_s;
  logic            out_val_s;
  logic [7:0]      out_char_s;
  logic            full_s;
  logic            xfer_s;
  logic [IW:0]     nxt_s;
  logic [IW:0]     first_s;

  assign full_s  = (line_chars_r == 16'(NCHARS - 1));
  assign xfer_s  = req_val[idx_r] && req_rdy_s[idx_r];
  assign nxt_s   = next_set(mask_r, int'(idx_r) + 1);
  assign first_s = next_set(line_mask, 0);

  // Character path: producer pass-through, separator, newline, or drop when full.
  always_comb begin
    req_rdy_s  = '0;
    out_val_s  = 1'b0;
    out_char_s = 8'h00;
    if (!reset) begin
      out_val_s = 1'b0;
    end else begin
      case (state_r)
        ST_XFER: begin
          if (!full_s) begin
            out_val_s         = req_val[idx_r];
            out_char_s        = req_char[{idx_r, 3'b000} +: 8];
            req_rdy_s[idx_r]  = out_rdy;
          end else begin
            req_rdy_s[idx_r]  = 1'b1;
          end
        end
        ST_SEP: begin
          if (!full_s) begin
            out_val_s  = 1'b1;
            out_char_s = SEP;
          end else begin
            out_val_s  = 1'b0;
          end
        end
        ST_NL: begin
          out_val_s  = 1'b1;
          out_char_s = 8'h0A;
        end
        default: begin
          out_val_s  = 1'b0;
        end
      endcase
    end
  end

  // Line sequencing, length/overflow bookkeeping and the free-running counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      idx_r        <= '0;
      mask_r       <= '0;
      line_chars_r <= 16'd0;
      overflow_r   <= 1'b0;
      line_done_r  <= 1'b0;
      cycles_r     <= 32'd0;
    end else begin
      cycles_r    <= cycles_r + 32'd1;
      line_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (line_start) begin
            mask_r       <= line_mask;
            line_chars_r <= 16'd0;
            overflow_r   <= 1'b0;
            if (first_s[IW]) begin
              idx_r   <= first_s[IW-1:0];
              state_r <= ST_XFER;
            end else begin
              state_r <= ST_NL;
            end
          end
        end
        ST_XFER: begin
          if (xfer_s) begin
            if (full_s) begin
              overflow_r   <= 1'b1;
            end else begin
              line_chars_r <= line_chars_r + 16'd1;
            end
            if (req_last[idx_r]) begin
              if (nxt_s[IW]) begin
                idx_r   <= nxt_s[IW-1:0];
                state_r <= ST_SEP;
              end else begin
                state_r <= ST_NL;
              end
            end
          end
        end
        ST_SEP: begin
          if (full_s) begin
            overflow_r <= 1'b1;
            state_r    <= ST_XFER;
          end else if (out_rdy) begin
            line_chars_r <= line_chars_r + 16'd1;
            state_r      <= ST_XFER;
          end
        end
        ST_NL: begin
          if (out_rdy) begin
            line_done_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_rdy    = req_rdy_s;
  assign out_val    = out_val_s;
  assign out_char   = out_char_s;
  assign line_done  = line_done_r;
  assign line_chars = line_chars_r;
  assign overflow   = overflow_r;
  assign cycles     = cycles_r;

endmodule
